// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Optional perf counters in the top are enabled by IFU_PERF_CNT_EN.
package ifu_pkg;

  localparam int unsigned INSTR_W = 32;

  localparam logic [INSTR_W-1:0] INSTR_NOP  = 32'hE1A0_0000;
  localparam logic [INSTR_W-1:0] PC_INC     = 32'd4;
  localparam logic [INSTR_W-1:0] ALIGN_MASK = 32'd3;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DRAIN
  } fetch_state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  function automatic logic [INSTR_W-1:0] align_word(input logic [INSTR_W-1:0] addr);
    return addr & ~ALIGN_MASK;
  endfunction

endpackage

// File: rtl/ifu_fifo.sv
// Prefetch FIFO of {pc, instr} entries with flush; head outputs are registered
// so the consumer sees flop outputs (instr forced to NOP while empty, pc held).
module ifu_fifo
  import ifu_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               push,
  input  logic               pop,
  input  fetch_entry_t       wdata,
  output logic [CNT_W-1:0]   count,
  output logic               valid,
  output logic [INSTR_W-1:0] head_pc,
  output logic [INSTR_W-1:0] head_instr
);

  fetch_entry_t       mem [DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr_n;
  logic [PTR_W-1:0]   wr_ptr_n;
  logic [CNT_W-1:0]   count_n;
  logic [CNT_W-1:0]   remain;
  logic               pop_ok;
  logic               push_ok;
  logic               valid_n;
  fetch_entry_t       head_n;

  // Flush beats push and pop; a push into a full FIFO is legal only alongside a pop.
  always_comb begin
    pop_ok   = pop && (count != '0) && !flush;
    push_ok  = push && !flush && ((count < CNT_W'(DEPTH)) || pop_ok);
    remain   = count - CNT_W'(pop_ok);
    count_n  = flush ? '0 : remain + CNT_W'(push_ok);
    rd_ptr_n = flush ? '0 : rd_ptr + PTR_W'(pop_ok);
    wr_ptr_n = flush ? '0 : wr_ptr + PTR_W'(push_ok);
    valid_n  = (count_n != '0);
    head_n   = (remain == '0) ? wdata : mem[rd_ptr_n];
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count      <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      valid      <= 1'b0;
      head_pc    <= '0;
      head_instr <= INSTR_NOP;
    end else begin
      count  <= count_n;
      rd_ptr <= rd_ptr_n;
      wr_ptr <= wr_ptr_n;
      valid  <= valid_n;
      if (valid_n) begin
        head_pc    <= head_n.pc;
        head_instr <= head_n.instr;
      end else begin
        head_instr <= INSTR_NOP;
      end
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns FetchPC, issues single-outstanding word reads and buffers
// returned words in ifu_fifo. Define IFU_PERF_CNT_EN to add FetchCount/FlushCount.
module instr_fetch_unit
  import ifu_pkg::*;
#(
  parameter logic [INSTR_W-1:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned        DEPTH    = 2
) (
  input  logic               CLK,
  input  logic               RESETn,
  output logic               IMemReq,
  output logic [INSTR_W-1:0] IMemAddr,
  input  logic               IMemAck,
  input  logic [INSTR_W-1:0] IMemRData,
  output logic [INSTR_W-1:0] Instr,
  output logic [INSTR_W-1:0] InstrPC,
  output logic               InstrValid,
  input  logic               InstrReady,
  input  logic               PCSrc,
  input  logic [INSTR_W-1:0] BranchTarget
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0]        FetchCount,
  output logic [15:0]        FlushCount
`endif
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  fetch_state_t       state;
  fetch_state_t       state_n;
  logic [INSTR_W-1:0] fetch_pc;
  logic [INSTR_W-1:0] fetch_pc_n;
  logic [INSTR_W-1:0] pc_next;
  logic [INSTR_W-1:0] target;
  logic [INSTR_W-1:0] addr_n;
  logic               req_n;
  logic               push;
  logic               pop;
  logic               flush;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   count_after;
  fetch_entry_t       wdata;

  assign target  = align_word(BranchTarget);
  assign pc_next = fetch_pc + PC_INC;
  assign pop     = InstrValid && InstrReady;
  assign wdata   = '{pc: fetch_pc, instr: IMemRData};

  // Occupancy after this edge's push and pop; decides whether the next read may issue.
  assign count_after = count + CNT_W'(1) - CNT_W'(pop);

  always_comb begin
    state_n    = state;
    fetch_pc_n = fetch_pc;
    req_n      = IMemReq;
    addr_n     = IMemAddr;
    push       = 1'b0;
    flush      = 1'b0;
    unique case (state)
      IDLE: begin
        if (PCSrc) begin
          flush      = 1'b1;
          fetch_pc_n = target;
          state_n    = REQ;
          req_n      = 1'b1;
          addr_n     = target;
        end else if (count < CNT_W'(DEPTH)) begin
          state_n = REQ;
          req_n   = 1'b1;
          addr_n  = fetch_pc;
        end
      end
      REQ: begin
        if (PCSrc) begin
          flush      = 1'b1;
          fetch_pc_n = target;
          if (IMemAck) begin
            req_n  = 1'b1;
            addr_n = target;
          end else begin
            state_n = DRAIN;
          end
        end else if (IMemAck) begin
          push       = 1'b1;
          fetch_pc_n = pc_next;
          if (count_after < CNT_W'(DEPTH)) begin
            req_n  = 1'b1;
            addr_n = pc_next;
          end else begin
            state_n = IDLE;
            req_n   = 1'b0;
          end
        end
      end
      DRAIN: begin
        // Stale read still owns the bus; its data is dropped when it completes.
        if (PCSrc) begin
          flush      = 1'b1;
          fetch_pc_n = target;
        end
        if (IMemAck) begin
          state_n = REQ;
          req_n   = 1'b1;
          addr_n  = PCSrc ? target : fetch_pc;
        end
      end
      default: begin
        state_n = IDLE;
        req_n   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      IMemReq  <= 1'b0;
      IMemAddr <= RESET_PC;
    end else begin
      state    <= state_n;
      fetch_pc <= fetch_pc_n;
      IMemReq  <= req_n;
      IMemAddr <= addr_n;
    end
  end

  ifu_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk        (CLK),
    .rst_n      (RESETn),
    .flush      (flush),
    .push       (push),
    .pop        (pop),
    .wdata      (wdata),
    .count      (count),
    .valid      (InstrValid),
    .head_pc    (InstrPC),
    .head_instr (Instr)
  );

`ifdef IFU_PERF_CNT_EN
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      FetchCount <= '0;
      FlushCount <= '0;
    end else begin
      if (push)  FetchCount <= FetchCount + 32'd1;
      if (PCSrc) FlushCount <= FlushCount + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a configurable-latency memory responder.
module tb_instr_fetch_unit;

  logic        CLK;
  logic        RESETn;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic        IMemAck;
  logic [31:0] IMemRData;
  logic [31:0] Instr;
  logic [31:0] InstrPC;
  logic        InstrValid;
  logic        InstrReady;
  logic        PCSrc;
  logic [31:0] BranchTarget;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] FetchCount;
  logic [15:0] FlushCount;
`endif

  int checks = 0;
  int errors = 0;

  int mem_lat  = 0;
  bit mem_hold = 0;
  int wait_cnt = 0;
  bit prev_req = 0;
  int ack_count = 0;

  localparam logic [31:0] NOP = 32'hE1A0_0000;

  instr_fetch_unit #(
    .RESET_PC(32'h0000_0000),
    .DEPTH(2)
  ) dut (
    .CLK          (CLK),
    .RESETn       (RESETn),
    .IMemReq      (IMemReq),
    .IMemAddr     (IMemAddr),
    .IMemAck      (IMemAck),
    .IMemRData    (IMemRData),
    .Instr        (Instr),
    .InstrPC      (InstrPC),
    .InstrValid   (InstrValid),
    .InstrReady   (InstrReady),
    .PCSrc        (PCSrc),
    .BranchTarget (BranchTarget)
`ifdef IFU_PERF_CNT_EN
    ,
    .FetchCount   (FetchCount),
    .FlushCount   (FlushCount)
`endif
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Memory responder: ack after mem_lat cycles of a request, unless held off.
  initial begin
    IMemAck   = 1'b0;
    IMemRData = 32'hDEAD_BEEF;
    forever begin
      @(posedge CLK);
      #1;
      if (IMemAck && prev_req) ack_count++;
      if (IMemReq && (!prev_req || IMemAck)) wait_cnt = 0;
      else if (IMemReq) wait_cnt++;
      prev_req  = IMemReq;
      IMemAck   = IMemReq && !mem_hold && (wait_cnt >= mem_lat);
      IMemRData = IMemAck ? mem_word(IMemAddr) : 32'hDEAD_BEEF;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge CLK);
  endtask

  task automatic reset_dut(input int lat, input bit ready);
    @(negedge CLK);
    RESETn       = 1'b0;
    PCSrc        = 1'b0;
    BranchTarget = '0;
    InstrReady   = ready;
    mem_lat      = lat;
    mem_hold     = 1'b0;
    step();
    step();
    RESETn = 1'b1;
  endtask

  task automatic test_reset();
    RESETn       = 1'b0;
    PCSrc        = 1'b0;
    BranchTarget = '0;
    InstrReady   = 1'b0;
    step();
    step();
    checks++; if (IMemReq !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", IMemReq); end
    checks++; if (IMemAddr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h exp 0", IMemAddr); end
    checks++; if (Instr !== NOP) begin errors++; $display("FAIL reset_instr got %h exp %h", Instr, NOP); end
    checks++; if (InstrPC !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp 0", InstrPC); end
    checks++; if (InstrValid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", InstrValid); end
  endtask

  task automatic test_stream();
    logic [31:0] exp_addr;
    logic [31:0] exp_pc;
    reset_dut(0, 1'b1);
    step();
    checks++; if (IMemReq !== 1'b1 || IMemAddr !== 32'h0) begin errors++; $display("FAIL stream_first_req got %b/%h exp 1/0", IMemReq, IMemAddr); end
    checks++; if (InstrValid !== 1'b0) begin errors++; $display("FAIL stream_early_valid got %b exp 0", InstrValid); end
    for (int k = 2; k <= 6; k++) begin
      step();
      exp_addr = 32'(4 * (k - 1));
      exp_pc   = 32'(4 * (k - 2));
      checks++; if (IMemAddr !== exp_addr) begin errors++; $display("FAIL stream_addr e%0d got %h exp %h", k, IMemAddr, exp_addr); end
      checks++; if (InstrValid !== 1'b1 || InstrPC !== exp_pc) begin errors++; $display("FAIL stream_pc e%0d got %b/%h exp 1/%h", k, InstrValid, InstrPC, exp_pc); end
      checks++; if (Instr !== mem_word(exp_pc)) begin errors++; $display("FAIL stream_instr e%0d got %h exp %h", k, Instr, mem_word(exp_pc)); end
    end
  endtask

  task automatic test_backpressure();
    int base;
    reset_dut(0, 1'b0);
    base = ack_count;
    for (int k = 1; k <= 5; k++) step();
    checks++; if (IMemReq !== 1'b0) begin errors++; $display("FAIL bp_req_low got %b exp 0", IMemReq); end
    checks++; if (ack_count - base !== 2) begin errors++; $display("FAIL bp_acks got %0d exp 2", ack_count - base); end
    checks++; if (InstrValid !== 1'b1 || InstrPC !== 32'h0) begin errors++; $display("FAIL bp_head got %b/%h exp 1/0", InstrValid, InstrPC); end
    InstrReady = 1'b1;
    step();
    checks++; if (InstrPC !== 32'h4 || IMemReq !== 1'b0) begin errors++; $display("FAIL bp_pop1 got %h/%b exp 4/0", InstrPC, IMemReq); end
    step();
    checks++; if (IMemReq !== 1'b1 || IMemAddr !== 32'h8) begin errors++; $display("FAIL bp_resume got %b/%h exp 1/8", IMemReq, IMemAddr); end
    checks++; if (InstrValid !== 1'b0 || InstrPC !== 32'h4) begin errors++; $display("FAIL bp_empty got %b/%h exp 0/4", InstrValid, InstrPC); end
    step();
    checks++; if (InstrValid !== 1'b1 || InstrPC !== 32'h8) begin errors++; $display("FAIL bp_fetch8 got %b/%h exp 1/8", InstrValid, InstrPC); end
  endtask

  task automatic test_redirect_drain();
    bit found;
    reset_dut(3, 1'b1);
    step();
    PCSrc        = 1'b1;
    BranchTarget = 32'h0000_0103;
    step();
    PCSrc = 1'b0;
    checks++; if (IMemReq !== 1'b1 || IMemAddr !== 32'h0 || InstrValid !== 1'b0) begin errors++; $display("FAIL drain_hold got %b/%h/%b exp 1/0/0", IMemReq, IMemAddr, InstrValid); end
    step();
    step();
    checks++; if (IMemReq !== 1'b1 || IMemAddr !== 32'h0) begin errors++; $display("FAIL drain_stable got %b/%h exp 1/0", IMemReq, IMemAddr); end
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      if (IMemAddr !== 32'h0) found = 1'b1;
    end
    checks++; if (!found || IMemAddr !== 32'h100 || InstrValid !== 1'b0) begin errors++; $display("FAIL drain_newaddr got %h/%b exp 100/0", IMemAddr, InstrValid); end
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      if (InstrValid === 1'b1) found = 1'b1;
    end
    checks++; if (!found || InstrPC !== 32'h100 || Instr !== mem_word(32'h100)) begin errors++; $display("FAIL drain_first got %b/%h/%h exp 1/100/%h", found, InstrPC, Instr, mem_word(32'h100)); end
  endtask

  task automatic test_redirect_collision();
    reset_dut(0, 1'b0);
    step();
    mem_hold = 1'b1;
    step();
    checks++; if (InstrValid !== 1'b1 || IMemReq !== 1'b1 || IMemAddr !== 32'h4) begin errors++; $display("FAIL coll_setup got %b/%b/%h exp 1/1/4", InstrValid, IMemReq, IMemAddr); end
    mem_hold = 1'b0;
    step();
    PCSrc        = 1'b1;
    BranchTarget = 32'h0000_0200;
    InstrReady   = 1'b1;
    step();
    PCSrc = 1'b0;
    checks++; if (InstrValid !== 1'b0 || Instr !== NOP || InstrPC !== 32'h0) begin errors++; $display("FAIL coll_flush got %b/%h/%h exp 0/%h/0", InstrValid, Instr, InstrPC, NOP); end
    checks++; if (IMemReq !== 1'b1 || IMemAddr !== 32'h200) begin errors++; $display("FAIL coll_target got %b/%h exp 1/200", IMemReq, IMemAddr); end
    step();
    checks++; if (InstrValid !== 1'b1 || InstrPC !== 32'h200) begin errors++; $display("FAIL coll_refill got %b/%h exp 1/200", InstrValid, InstrPC); end
  endtask

  task automatic test_reset_mid();
    reset_dut(0, 1'b0);
    step();
    step();
    checks++; if (InstrValid !== 1'b1 || IMemReq !== 1'b1) begin errors++; $display("FAIL rmid_setup got %b/%b exp 1/1", InstrValid, IMemReq); end
    RESETn = 1'b0;
    #1;
    checks++; if (IMemReq !== 1'b0 || InstrValid !== 1'b0) begin errors++; $display("FAIL rmid_async got %b/%b exp 0/0", IMemReq, InstrValid); end
    checks++; if (IMemAddr !== 32'h0 || Instr !== NOP) begin errors++; $display("FAIL rmid_vals got %h/%h exp 0/%h", IMemAddr, Instr, NOP); end
    step();
    RESETn = 1'b1;
    step();
    checks++; if (IMemReq !== 1'b1 || IMemAddr !== 32'h0) begin errors++; $display("FAIL rmid_restart got %b/%h exp 1/0", IMemReq, IMemAddr); end
    step();
    checks++; if (InstrValid !== 1'b1 || InstrPC !== 32'h0) begin errors++; $display("FAIL rmid_first got %b/%h exp 1/0", InstrValid, InstrPC); end
  endtask

  task automatic test_wrap_and_counters();
    reset_dut(0, 1'b1);
    step();
    PCSrc        = 1'b1;
    BranchTarget = 32'hFFFF_FFFF;
    step();
    PCSrc = 1'b0;
    checks++; if (IMemAddr !== 32'hFFFF_FFFC || InstrValid !== 1'b0) begin errors++; $display("FAIL wrap_target got %h/%b exp fffffffc/0", IMemAddr, InstrValid); end
    step();
    checks++; if (InstrPC !== 32'hFFFF_FFFC || IMemAddr !== 32'h0) begin errors++; $display("FAIL wrap_pc got %h/%h exp fffffffc/0", InstrPC, IMemAddr); end
    step();
    checks++; if (InstrPC !== 32'h0 || IMemAddr !== 32'h4) begin errors++; $display("FAIL wrap_next got %h/%h exp 0/4", InstrPC, IMemAddr); end
    step();
    step();
    step();
    PCSrc        = 1'b1;
    BranchTarget = 32'h0000_0040;
    step();
    PCSrc = 1'b0;
    for (int k = 9; k <= 12; k++) step();
    mem_hold = 1'b1;
    step();
    checks++; if (InstrValid !== 1'b1 || InstrPC !== 32'h50) begin errors++; $display("FAIL cnt_last got %b/%h exp 1/50", InstrValid, InstrPC); end
    step();
    checks++; if (InstrValid !== 1'b0 || InstrPC !== 32'h50 || Instr !== NOP) begin errors++; $display("FAIL hold_pc got %b/%h/%h exp 0/50/%h", InstrValid, InstrPC, Instr, NOP); end
`ifdef IFU_PERF_CNT_EN
    checks++; if (FetchCount !== 32'd10) begin errors++; $display("FAIL fetch_count got %0d exp 10", FetchCount); end
    checks++; if (FlushCount !== 16'd2) begin errors++; $display("FAIL flush_count got %0d exp 2", FlushCount); end
`endif
    mem_hold = 1'b0;
  endtask

  initial begin
    RESETn       = 1'b0;
    InstrReady   = 1'b0;
    PCSrc        = 1'b0;
    BranchTarget = '0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_drain();
    test_redirect_collision();
    test_reset_mid();
    test_wrap_and_counters();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
